player_bullet_pool: RTL and testbench



---
 rtl/game_pkg.sv | 34 +++
 rtl/free_slot_finder.sv | 24 ++
 rtl/player_bullet_pool.sv | 153 +++++++++++++++
 tb/tb_player_bullet_pool.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game constants: state codes, parking coordinate, bullet/player geometry.
package game_pkg;

    typedef enum logic [2:0] {
        GAME_IDLE    = 3'd0,
        GAME_PLAYING = 3'd1,
        GAME_VICTORY = 3'd2,
        GAME_DEFEAT  = 3'd3,
        GAME_ERROR   = 3'd4
    } game_state_e;

    localparam int unsigned X_W        = 10;
    localparam int unsigned Y_W        = 9;
    localparam int unsigned SLOT_IDX_W = 4;
    localparam int unsigned COOLDOWN_W = 4;

    localparam int unsigned MAX_PLAYER_BULLET   = 15;
    localparam int unsigned PLAYER_BULLET_SPEED = 4;
    localparam int unsigned MAX_PLAYER_COOLDOWN = 11;

    localparam int unsigned BULLET_WIDTH  = 4;
    localparam int unsigned BULLET_HEIGHT = 16;
    localparam int unsigned PLAYER_HEIGHT = 36;

    localparam int unsigned NONE_X = 720;
    localparam int unsigned NONE_Y = 500;

    // Vertical distance from player centre to the top-left of a freshly spawned bullet.
    function automatic logic [Y_W-1:0] spawn_dy(input int unsigned player_h,
                                                 input int unsigned bullet_h);
        return Y_W'(player_h / 2 + bullet_h);
    endfunction

endpackage

// File: rtl/free_slot_finder.sv
// Combinational priority encoder: lowest-index slot whose alive bit is clear.
module free_slot_finder
    import game_pkg::*;
#(
    parameter int unsigned NumSlots = MAX_PLAYER_BULLET
) (
    input  logic [NumSlots-1:0]   alive_i,
    output logic [SLOT_IDX_W-1:0] idx_o,
    output logic                  found_o
);

    // Scan from the top down so the lowest free index is the last one written.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (!alive_i[i]) begin
                idx_o   = SLOT_IDX_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/player_bullet_pool.sv
// Fixed-slot pool of player bullets: spawn on fire, move up per frame, despawn at top or on hit.
module player_bullet_pool
    import game_pkg::*;
#(
    parameter int unsigned PlayerBulletSpeed = PLAYER_BULLET_SPEED,
    parameter int unsigned MaxPlayerCooldown = MAX_PLAYER_COOLDOWN,
    parameter int unsigned BulletWidth       = BULLET_WIDTH,
    parameter int unsigned BulletHeight      = BULLET_HEIGHT,
    parameter int unsigned PlayerHeight      = PLAYER_HEIGHT,
    parameter int unsigned NoneX             = NONE_X,
    parameter int unsigned NoneY             = NONE_Y
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             frame_tick_i,
    input  logic [2:0]                       game_state_i,
    input  logic                             fire_i,
    input  logic [X_W-1:0]                   player_x_i,
    input  logic [Y_W-1:0]                   player_y_i,
    input  logic                             hit_valid_i,
    input  logic [SLOT_IDX_W-1:0]            hit_idx_i,
    output logic [MAX_PLAYER_BULLET*X_W-1:0] bullet_x_o,
    output logic [MAX_PLAYER_BULLET*Y_W-1:0] bullet_y_o,
    output logic [MAX_PLAYER_BULLET-1:0]     bullet_alive_o,
    output logic                             fired_o,
    output logic                             pool_full_o
);

    localparam int unsigned N = MAX_PLAYER_BULLET;

    localparam logic [Y_W-1:0]        Speed       = Y_W'(PlayerBulletSpeed);
    localparam logic [X_W-1:0]        SpawnDx     = X_W'(BulletWidth / 2);
    localparam logic [Y_W-1:0]        SpawnDy     = spawn_dy(PlayerHeight, BulletHeight);
    localparam logic [COOLDOWN_W-1:0] CooldownMax = COOLDOWN_W'(MaxPlayerCooldown);
    localparam logic [X_W-1:0]        ParkX       = X_W'(NoneX);
    localparam logic [Y_W-1:0]        ParkY       = Y_W'(NoneY);

    logic [X_W-1:0]        x_q [N];
    logic [X_W-1:0]        x_d [N];
    logic [Y_W-1:0]        y_q [N];
    logic [Y_W-1:0]        y_d [N];
    logic [N-1:0]          alive_q, alive_d;
    logic [COOLDOWN_W-1:0] cooldown_q, cooldown_d;
    logic                  fired_q, fired_d;

    logic [N-1:0]          hit_mask;
    logic [SLOT_IDX_W-1:0] free_idx;
    logic                  free_found;
    logic                  spawn_ok;

    // The hit slot is still live here, so it is never chosen as this cycle's spawn target.
    free_slot_finder #(
        .NumSlots (N)
    ) u_free_slot_finder (
        .alive_i (alive_q),
        .idx_o   (free_idx),
        .found_o (free_found)
    );

    // Decode a valid hit report into a one-hot mask of the live slot it frees.
    always_comb begin
        hit_mask = '0;
        if (hit_valid_i && (hit_idx_i < SLOT_IDX_W'(N))) begin
            hit_mask[hit_idx_i] = alive_q[hit_idx_i];
        end
    end

    assign spawn_ok = fire_i && (cooldown_q == '0) && free_found && (player_y_i >= SpawnDy);

    // Next-state: clear in idle, step/spawn/hit while playing, hold in every other state.
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        alive_d    = alive_q;
        cooldown_d = cooldown_q;
        fired_d    = 1'b0;
        case (game_state_i)
            GAME_IDLE: begin
                for (int i = 0; i < N; i++) begin
                    x_d[i] = ParkX;
                    y_d[i] = ParkY;
                end
                alive_d    = '0;
                cooldown_d = '0;
            end
            GAME_PLAYING: begin
                for (int i = 0; i < N; i++) begin
                    if (hit_mask[i]) begin
                        x_d[i]     = ParkX;
                        y_d[i]     = ParkY;
                        alive_d[i] = 1'b0;
                    end else if (frame_tick_i && alive_q[i]) begin
                        if (y_q[i] < Speed) begin
                            x_d[i]     = ParkX;
                            y_d[i]     = ParkY;
                            alive_d[i] = 1'b0;
                        end else begin
                            y_d[i] = y_q[i] - Speed;
                        end
                    end
                end
                if (frame_tick_i) begin
                    if (spawn_ok) begin
                        x_d[free_idx]     = player_x_i - SpawnDx;
                        y_d[free_idx]     = player_y_i - SpawnDy;
                        alive_d[free_idx] = 1'b1;
                        cooldown_d        = CooldownMax;
                        fired_d           = 1'b1;
                    end else if (cooldown_q != '0) begin
                        cooldown_d = cooldown_q - 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N; i++) begin
                x_q[i] <= ParkX;
                y_q[i] <= ParkY;
            end
            alive_q    <= '0;
            cooldown_q <= '0;
            fired_q    <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
            alive_q    <= alive_d;
            cooldown_q <= cooldown_d;
            fired_q    <= fired_d;
        end
    end

    // Flatten slot registers onto the position buses, slot 0 in the LSBs.
    always_comb begin
        bullet_x_o = '0;
        bullet_y_o = '0;
        for (int i = 0; i < N; i++) begin
            bullet_x_o[i*X_W +: X_W] = x_q[i];
            bullet_y_o[i*Y_W +: Y_W] = y_q[i];
        end
    end

    assign bullet_alive_o = alive_q;
    assign fired_o        = fired_q;
    assign pool_full_o    = &alive_q;

endmodule

// File: tb/tb_player_bullet_pool.sv
// Bench for player_bullet_pool: directed scenarios plus randomized traffic against a slot model.
module tb_player_bullet_pool;
    import game_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, tick, fire, hv;
    logic [2:0] gs;
    logic [9:0] px;
    logic [8:0] py;
    logic [3:0] hidx;

    // Instance 0 uses the default cooldown; instance 1 has no cooldown so the pool can be filled.
    logic [149:0] bx, fx;
    logic [134:0] by, fy;
    logic [14:0]  ba, fa;
    logic         bf, ff, bp, fp;

    player_bullet_pool u_dut (
        .clk_i (clk), .rst_i (rst), .frame_tick_i (tick), .game_state_i (gs), .fire_i (fire),
        .player_x_i (px), .player_y_i (py), .hit_valid_i (hv), .hit_idx_i (hidx),
        .bullet_x_o (bx), .bullet_y_o (by), .bullet_alive_o (ba), .fired_o (bf),
        .pool_full_o (bp)
    );

    player_bullet_pool #(
        .MaxPlayerCooldown (0)
    ) u_dut_fast (
        .clk_i (clk), .rst_i (rst), .frame_tick_i (tick), .game_state_i (gs), .fire_i (fire),
        .player_x_i (px), .player_y_i (py), .hit_valid_i (hv), .hit_idx_i (hidx),
        .bullet_x_o (fx), .bullet_y_o (fy), .bullet_alive_o (fa), .fired_o (ff),
        .pool_full_o (fp)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: per-instance slot arrays updated from the rules once per clock.
    logic [9:0] mx [2][15];
    logic [8:0] my [2][15];
    logic       ma [2][15];
    int         mcd [2];
    logic       mf [2];
    int         cdmax [2] = '{11, 0};

    task automatic park(input int d, input int i);
        mx[d][i] = 10'd720;
        my[d][i] = 9'd500;
        ma[d][i] = 1'b0;
    endtask

    task automatic model_next();
        int hit;
        int fr;
        for (int d = 0; d < 2; d++) begin
            mf[d] = 1'b0;
            if (rst || gs == 3'd0) begin
                for (int i = 0; i < 15; i++) park(d, i);
                mcd[d] = 0;
            end else if (gs == 3'd1) begin
                hit = -1;
                if (hv && hidx < 4'd15 && ma[d][hidx]) hit = int'(hidx);
                fr = -1;
                for (int i = 14; i >= 0; i--) if (!ma[d][i]) fr = i;
                if (hit >= 0) park(d, hit);
                if (tick) begin
                    for (int i = 0; i < 15; i++) begin
                        if (ma[d][i] && i != hit) begin
                            if (int'(my[d][i]) < 4) park(d, i);
                            else my[d][i] = my[d][i] - 9'd4;
                        end
                    end
                    if (fire && mcd[d] == 0 && fr >= 0 && int'(py) >= 34) begin
                        mx[d][fr] = px - 10'd2;
                        my[d][fr] = py - 9'd34;
                        ma[d][fr] = 1'b1;
                        mcd[d]    = cdmax[d];
                        mf[d]     = 1'b1;
                    end else if (mcd[d] > 0) begin
                        mcd[d] = mcd[d] - 1;
                    end
                end
            end
        end
    endtask

    function automatic logic [149:0] pk_x(input int d);
        logic [149:0] r;
        for (int i = 0; i < 15; i++) r[i*10 +: 10] = mx[d][i];
        return r;
    endfunction

    function automatic logic [134:0] pk_y(input int d);
        logic [134:0] r;
        for (int i = 0; i < 15; i++) r[i*9 +: 9] = my[d][i];
        return r;
    endfunction

    function automatic logic [14:0] pk_a(input int d);
        logic [14:0] r;
        for (int i = 0; i < 15; i++) r[i] = ma[d][i];
        return r;
    endfunction

    task automatic step();
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1; tick = 1'b0; fire = 1'b0; hv = 1'b0; hidx = 4'd0;
        gs = GAME_IDLE; px = 10'd302; py = 9'd372;
        step();
        rst = 1'b0;
        gs  = GAME_PLAYING;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (ba !== 15'h0000 || bf !== 1'b0 || bp !== 1'b0) begin
            bad++; $display("FAIL reset_flags got alive=%h fired=%b full=%b want 0", ba, bf, bp);
        end
        total++;
        if (bx !== {15{10'd720}} || by !== {15{9'd500}}) begin
            bad++; $display("FAIL reset_pos got x=%h y=%h want parked", bx, by);
        end
    endtask

    task automatic test_first_shot();
        do_reset();
        fire = 1'b1;
        tick = 1'b1;
        step();
        tick = 1'b0;
        fire = 1'b0;
        total++;
        if (bx[9:0] !== 10'd300 || by[8:0] !== 9'd338 || ba !== 15'h0001) begin
            bad++;
            $display("FAIL first_shot got (%0d,%0d) alive=%h want (300,338) 0001",
                     bx[9:0], by[8:0], ba);
        end
        total++;
        if (bf !== 1'b1) begin bad++; $display("FAIL first_fired got %b want 1", bf); end
        step();
        total++;
        if (bf !== 1'b0) begin bad++; $display("FAIL fired_pulse got %b want 0", bf); end
    endtask

    task automatic test_fire_held();
        logic exp;
        do_reset();
        fire = 1'b1;
        for (int t = 1; t <= 24; t++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            exp = (t == 1 || t == 13);
            total++;
            if (bf !== exp) begin
                bad++; $display("FAIL held_fired tick=%0d got %b want %b", t, bf, exp);
            end
            if (t == 13) begin
                total++;
                if (by[8:0] !== 9'd290 || by[17:9] !== 9'd338) begin
                    bad++;
                    $display("FAIL held_y got s0=%0d s1=%0d want 290 338", by[8:0], by[17:9]);
                end
            end
            step();
        end
        total++;
        if (ba !== 15'h0003) begin bad++; $display("FAIL held_alive got %h want 0003", ba); end
    endtask

    task automatic test_lifetime();
        do_reset();
        fire = 1'b1;
        tick_step();
        fire = 1'b0;
        for (int t = 0; t < 84; t++) tick_step();
        total++;
        if (ba[0] !== 1'b1 || by[8:0] !== 9'd2) begin
            bad++; $display("FAIL life_84 got alive=%b y=%0d want 1 2", ba[0], by[8:0]);
        end
        tick_step();
        total++;
        if (ba[0] !== 1'b0 || bx[9:0] !== 10'd720 || by[8:0] !== 9'd500) begin
            bad++;
            $display("FAIL life_85 got alive=%b (%0d,%0d) want 0 (720,500)",
                     ba[0], bx[9:0], by[8:0]);
        end
    endtask

    task automatic test_spawn_limit();
        do_reset();
        fire = 1'b1;
        py   = 9'd33;
        tick = 1'b1;
        step();
        total++;
        if (ba !== 15'h0000 || bf !== 1'b0) begin
            bad++; $display("FAIL low_player got alive=%h fired=%b want 0000 0", ba, bf);
        end
        py = 9'd34;
        step();
        total++;
        if (ba[0] !== 1'b1 || by[8:0] !== 9'd0 || bf !== 1'b1) begin
            bad++;
            $display("FAIL edge_player got alive=%b y=%0d fired=%b want 1 0 1", ba[0], by[8:0], bf);
        end
        fire = 1'b0;
        step();
        tick = 1'b0;
        total++;
        if (ba[0] !== 1'b0) begin bad++; $display("FAIL top_despawn got %b want 0", ba[0]); end
        py = 9'd372;
    endtask

    task automatic test_pool_full();
        do_reset();
        fire = 1'b1;
        for (int t = 0; t < 15; t++) tick_step();
        total++;
        if (fa !== 15'h7fff || fp !== 1'b1) begin
            bad++; $display("FAIL pool_full got alive=%h full=%b want 7fff 1", fa, fp);
        end
        tick = 1'b1;
        step();
        tick = 1'b0;
        total++;
        if (ff !== 1'b0 || fa !== 15'h7fff) begin
            bad++; $display("FAIL full_nospawn got fired=%b alive=%h want 0 7fff", ff, fa);
        end
        hv = 1'b1; hidx = 4'd7;
        step();
        hv = 1'b0;
        total++;
        if (fa !== 15'h7f7f || fp !== 1'b0) begin
            bad++; $display("FAIL hit7 got alive=%h full=%b want 7f7f 0", fa, fp);
        end
        tick = 1'b1;
        step();
        tick = 1'b0;
        total++;
        if (ff !== 1'b1 || fa !== 15'h7fff || fx[79:70] !== 10'd300 || fy[71:63] !== 9'd338) begin
            bad++;
            $display("FAIL refill7 got fired=%b alive=%h (%0d,%0d) want 1 7fff (300,338)",
                     ff, fa, fx[79:70], fy[71:63]);
        end
        fire = 1'b0;
    endtask

    task automatic test_hit_tick();
        do_reset();
        fire = 1'b1;
        for (int t = 0; t < 4; t++) tick_step();
        hv = 1'b1; hidx = 4'd3; tick = 1'b1;
        step();
        hv = 1'b0; tick = 1'b0; fire = 1'b0;
        total++;
        if (fa !== 15'h0017 || ff !== 1'b1) begin
            bad++; $display("FAIL hit_tick_alive got %h fired=%b want 0017 1", fa, ff);
        end
        total++;
        if (fy[8:0] !== 9'd322 || fy[17:9] !== 9'd326 || fy[26:18] !== 9'd330 ||
            fy[35:27] !== 9'd500 || fy[44:36] !== 9'd338) begin
            bad++;
            $display("FAIL hit_tick_y got %0d %0d %0d %0d %0d want 322 326 330 500 338",
                     fy[8:0], fy[17:9], fy[26:18], fy[35:27], fy[44:36]);
        end
        hv = 1'b1; hidx = 4'd15;
        step();
        hv = 1'b0;
        total++;
        if (fa !== 15'h0017) begin bad++; $display("FAIL hit_oob got %h want 0017", fa); end
    endtask

    task automatic test_freeze();
        do_reset();
        fire = 1'b1;
        for (int t = 0; t < 6; t++) tick_step();
        gs = GAME_DEFEAT;
        hv = 1'b1; hidx = 4'd0;
        for (int t = 0; t < 5; t++) tick_step();
        hv = 1'b0;
        total++;
        if (ba !== 15'h0001 || by[8:0] !== 9'd318 || bx[9:0] !== 10'd300 || bf !== 1'b0) begin
            bad++;
            $display("FAIL freeze got alive=%h (%0d,%0d) fired=%b want 0001 (300,318) 0",
                     ba, bx[9:0], by[8:0], bf);
        end
        gs = GAME_IDLE;
        step();
        total++;
        if (ba !== 15'h0000 || bx !== {15{10'd720}} || by !== {15{9'd500}}) begin
            bad++; $display("FAIL idle_clear got alive=%h x=%h y=%h want parked", ba, bx, by);
        end
        gs = GAME_PLAYING;
        tick = 1'b1;
        step();
        tick = 1'b0;
        total++;
        if (bf !== 1'b1) begin bad++; $display("FAIL idle_cooldown got fired=%b want 1", bf); end
        fire = 1'b0;
    endtask

    task automatic test_random();
        logic [149:0] ax;
        logic [134:0] ay;
        logic [14:0]  aa;
        logic         af, ap;
        int           r;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 199) == 0) begin
                r = $urandom_range(0, 9);
                gs = (r < 6) ? 3'd1 : (r == 6) ? 3'd0 : 3'($urandom_range(2, 4));
            end
            tick = ($urandom_range(0, 2) == 0);
            fire = ($urandom_range(0, 3) != 0);
            px   = 10'($urandom_range(2, 639));
            py   = 9'($urandom_range(0, 479));
            hv   = ($urandom_range(0, 4) == 0);
            hidx = 4'($urandom_range(0, 15));
            step();
            for (int d = 0; d < 2; d++) begin
                ax = d ? fx : bx; ay = d ? fy : by; aa = d ? fa : ba;
                af = d ? ff : bf; ap = d ? fp : bp;
                total++;
                if (ax !== pk_x(d) || ay !== pk_y(d)) begin
                    bad++;
                    $display("FAIL rnd_pos inst=%0d cyc=%0d got x=%h y=%h want x=%h y=%h",
                             d, c, ax, ay, pk_x(d), pk_y(d));
                end
                total++;
                if (aa !== pk_a(d) || af !== mf[d] || ap !== (&pk_a(d))) begin
                    bad++;
                    $display("FAIL rnd_flags inst=%0d cyc=%0d got a=%h f=%b p=%b want a=%h f=%b",
                             d, c, aa, af, ap, pk_a(d), mf[d]);
                end
            end
        end
        rst = 1'b0; tick = 1'b0; fire = 1'b0; hv = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_shot();
        test_fire_held();
        test_lifetime();
        test_spawn_limit();
        test_pool_full();
        test_hit_tick();
        test_freeze();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
